btn_move_conditioner: RTL and testbench

- Front end for the tic-tac-toe cursor/turn controller: conditions the five raw board push-buttons (up, down, left, right, center).
- Per button: synchronises, debounces, and converts each press into a single-cycle move pulse.
- Enforces a one-gesture-per-press lock, so the downstream state machine sees exactly one clean direction or place event per physical press and never sees bounce or overlapping presses.

---
 rtl/btn_move_pkg.sv | 34 +++
 rtl/btn_move_conditioner_if.sv | 28 ++
 rtl/btn_debounce.sv | 97 +++++++++
 rtl/btn_move_conditioner.sv | 149 ++++++++++++++
 tb/tb_btn_move_conditioner.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/btn_move_pkg.sv
// Shared types and constants for the tic-tac-toe button conditioner:
// debounce FSM states, button indices and last-direction codes.
package btn_move_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DB_PRESS = 2'd1,
    ST_HELD     = 2'd2,
    ST_DB_REL   = 2'd3
  } btn_state_t;

  localparam int BTN_UP     = 0;
  localparam int BTN_DOWN   = 1;
  localparam int BTN_LEFT   = 2;
  localparam int BTN_RIGHT  = 3;
  localparam int BTN_CENTER = 4;
  localparam int NUM_BTN    = 5;
  localparam int NUM_DIR    = 4;

  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_DOWN  = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_RIGHT = 3'd4,
    DIR_PLACE = 3'd5
  } dir_t;

  // Debounced level is high while the press is accepted or releasing.
  function automatic logic is_pressed(input btn_state_t s);
    return (s == ST_HELD) || (s == ST_DB_REL);
  endfunction

endpackage

// File: rtl/btn_move_conditioner_if.sv
// Button bus: raw board buttons in, conditioned move pulses and status out.
// The slave side (the conditioner) samples btn_raw and drives every other signal.
interface btn_move_conditioner_if;
  import btn_move_pkg::*;

  logic [4:0] btn_raw;
  logic       up_pulse;
  logic       down_pulse;
  logic       left_pulse;
  logic       right_pulse;
  logic       place_pulse;
  logic       any_held;
  dir_t       last_dir;

  // Pulses are single-cycle strobes with no ready: the consumer must take them
  // in the cycle they are high, and at most one pulse is high per cycle.
  modport master (
    output btn_raw,
    input  up_pulse, down_pulse, left_pulse, right_pulse, place_pulse,
    input  any_held, last_dir
  );

  modport slave (
    input  btn_raw,
    output up_pulse, down_pulse, left_pulse, right_pulse, place_pulse,
    output any_held, last_dir
  );
endinterface

// File: rtl/btn_debounce.sv
// One button: 2-flop synchroniser, stable-level counter and 4-state debounce FSM.
// rise is a registered one-cycle strobe on the IDLE->HELD acceptance.
module btn_debounce
  import btn_move_pkg::*;
#(
  parameter int DB_CYCLES = 250000,
  parameter int CNT_W     = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       raw,
  output logic       level,
  output logic       rise,
  output btn_state_t state
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  btn_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise_q, rise_d;
  logic             level_q, level_d;

  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (sync2_q) state_d = ST_DB_PRESS;
      end
      ST_DB_PRESS: begin
        if (!sync2_q) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_HELD;
          cnt_d   = '0;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HELD: begin
        if (!sync2_q) begin
          state_d = ST_DB_REL;
          cnt_d   = '0;
        end
      end
      ST_DB_REL: begin
        // A bounce back high during release is the same press, not a new one.
        if (sync2_q) begin
          state_d = ST_HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    level_d = is_pressed(state_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      level_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign state = state_q;

endmodule

// File: rtl/btn_move_conditioner.sv
// Five-button front end: debounce, one-gesture-per-press lock, priority and move pulses.
// Define BTN_MOVE_AUTOREPEAT_EN to re-emit held direction presses.
module btn_move_conditioner
  import btn_move_pkg::*;
#(
  parameter int DB_CYCLES  = 250000,
  parameter int CNT_W      = 18,
  parameter int RPT_DELAY  = 25000000,
  parameter int RPT_PERIOD = 10000000
) (
  input logic                   clk,
  input logic                   rst,
  btn_move_conditioner_if.slave bus
);

  logic [NUM_BTN-1:0] level;
  logic [NUM_BTN-1:0] rise;
  btn_state_t         btn_st [NUM_BTN];

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_debounce #(
      .DB_CYCLES(DB_CYCLES),
      .CNT_W    (CNT_W)
    ) u_db (
      .clk  (clk),
      .rst  (rst),
      .raw  (bus.btn_raw[g]),
      .level(level[g]),
      .rise (rise[g]),
      .state(btn_st[g])
    );
  end

  logic [NUM_BTN-1:0] pulse_q, pulse_d;
  dir_t               last_dir_q, last_dir_d;
  logic               any_held_q, any_held_d;
  logic [NUM_BTN-1:0] held_before;
  logic [NUM_BTN-1:0] req;
  logic               others;
  logic [NUM_DIR-1:0] rpt_fire;

  always_comb begin
    // A button rising this cycle shows level=1 too; only earlier holds lock others out.
    held_before = level & ~rise;
    req         = '0;
    others      = 1'b0;
    for (int i = 0; i < NUM_BTN; i++) begin
      others = 1'b0;
      for (int j = 0; j < NUM_BTN; j++) begin
        if (j != i) others = others | held_before[j];
      end
      req[i] = rise[i] & ~others;
    end
    req[NUM_DIR-1:0] = req[NUM_DIR-1:0] | rpt_fire;

    pulse_d    = '0;
    last_dir_d = last_dir_q;
    if (req[BTN_CENTER]) begin
      pulse_d[BTN_CENTER] = 1'b1;
      last_dir_d          = DIR_PLACE;
    end else if (req[BTN_UP]) begin
      pulse_d[BTN_UP] = 1'b1;
      last_dir_d      = DIR_UP;
    end else if (req[BTN_DOWN]) begin
      pulse_d[BTN_DOWN] = 1'b1;
      last_dir_d        = DIR_DOWN;
    end else if (req[BTN_LEFT]) begin
      pulse_d[BTN_LEFT] = 1'b1;
      last_dir_d        = DIR_LEFT;
    end else if (req[BTN_RIGHT]) begin
      pulse_d[BTN_RIGHT] = 1'b1;
      last_dir_d         = DIR_RIGHT;
    end

    any_held_d = 1'b0;
    for (int i = 0; i < NUM_BTN; i++) begin
      any_held_d = any_held_d | is_pressed(btn_st[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pulse_q    <= '0;
      last_dir_q <= DIR_NONE;
      any_held_q <= 1'b0;
    end else begin
      pulse_q    <= pulse_d;
      last_dir_q <= last_dir_d;
      any_held_q <= any_held_d;
    end
  end

`ifdef BTN_MOVE_AUTOREPEAT_EN
  localparam int RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
  localparam int RPT_CW  = $clog2(RPT_MAX);
  localparam logic [RPT_CW-1:0] RPT_FIRST = RPT_CW'(RPT_DELAY - 1);
  localparam logic [RPT_CW-1:0] RPT_NEXT  = RPT_CW'(RPT_PERIOD - 1);

  // acc: this press produced a pulse; rptd: at least one repeat since entering HELD.
  logic [RPT_CW-1:0]  rpt_cnt_q [NUM_DIR];
  logic [RPT_CW-1:0]  rpt_cnt_d [NUM_DIR];
  logic [NUM_DIR-1:0] acc_q, acc_d;
  logic [NUM_DIR-1:0] rptd_q, rptd_d;

  always_comb begin
    for (int i = 0; i < NUM_DIR; i++) begin
      rpt_fire[i] = acc_q[i] && (btn_st[i] == ST_HELD) &&
                    (rpt_cnt_q[i] == (rptd_q[i] ? RPT_NEXT : RPT_FIRST));
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_DIR; i++) begin
      acc_d[i]  = is_pressed(btn_st[i]) && (acc_q[i] || pulse_d[i]);
      rptd_d[i] = (btn_st[i] == ST_HELD) && (rptd_q[i] || (pulse_d[i] && acc_q[i]));
      if (pulse_d[i]) begin
        rpt_cnt_d[i] = '0;
      end else if (acc_q[i] && (btn_st[i] == ST_HELD)) begin
        rpt_cnt_d[i] = rpt_cnt_q[i] + 1'b1;
      end else begin
        rpt_cnt_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      rptd_q <= '0;
      for (int i = 0; i < NUM_DIR; i++) rpt_cnt_q[i] <= '0;
    end else begin
      acc_q  <= acc_d;
      rptd_q <= rptd_d;
      for (int i = 0; i < NUM_DIR; i++) rpt_cnt_q[i] <= rpt_cnt_d[i];
    end
  end
`else
  assign rpt_fire = '0;
`endif

  assign bus.up_pulse    = pulse_q[BTN_UP];
  assign bus.down_pulse  = pulse_q[BTN_DOWN];
  assign bus.left_pulse  = pulse_q[BTN_LEFT];
  assign bus.right_pulse = pulse_q[BTN_RIGHT];
  assign bus.place_pulse = pulse_q[BTN_CENTER];
  assign bus.any_held    = any_held_q;
  assign bus.last_dir    = last_dir_q;

endmodule

// File: tb/tb_btn_move_conditioner.sv
// Directed bench for btn_move_conditioner with DB_CYCLES=4, RPT_DELAY=20, RPT_PERIOD=8.
// A press driven before step 1 yields its pulse at step 8 (DB_CYCLES+4 edges later).
module tb_btn_move_conditioner;
  import btn_move_pkg::*;

  localparam int DB  = 4;
  localparam int LAT = DB + 4;
`ifdef BTN_MOVE_AUTOREPEAT_EN
  localparam int EXP_UP_CLEAN = 2;
`else
  localparam int EXP_UP_CLEAN = 1;
`endif

  logic clk;
  logic rst;
  btn_move_conditioner_if bus ();

  btn_move_conditioner #(
    .DB_CYCLES (DB),
    .CNT_W     (3),
    .RPT_DELAY (20),
    .RPT_PERIOD(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_total = 0;
  int          n_pass  = 0;
  int          n_fail  = 0;
  int          idx;
  int          pcnt  [5];
  int          first [5];
  int          held_cycles;
  int          multi = 0;
  logic [31:0] up_steps [$];
  logic [31:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    idx         = 0;
    held_cycles = 0;
    for (int b = 0; b < 5; b++) begin
      pcnt[b]  = 0;
      first[b] = 0;
    end
    up_steps.delete();
  endtask

  // driver/monitor: advance n edges, sample 1 time unit after each
  task automatic run(input int n);
    logic [4:0] p;
    for (int s = 0; s < n; s++) begin
      @(posedge clk);
      #1;
      idx++;
      p = {bus.place_pulse, bus.right_pulse, bus.left_pulse, bus.down_pulse, bus.up_pulse};
      if ($countones(p) > 1) multi++;
      for (int b = 0; b < 5; b++) begin
        if (p[b]) begin
          pcnt[b]++;
          if (first[b] == 0) first[b] = idx;
        end
      end
      if (p[0]) up_steps.push_back(32'(idx));
      if (bus.any_held) held_cycles++;
    end
  endtask

  function automatic int pulse_sum();
    return pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3] + pcnt[4];
  endfunction

  initial begin
    int idx0;
    rst         = 1'b1;
    bus.btn_raw = 5'b00000;
    clear_mon();
    run(3);
    chk("reset_pulses", 32'({bus.place_pulse, bus.right_pulse, bus.left_pulse,
                             bus.down_pulse, bus.up_pulse}), 0);
    chk("reset_any_held", 32'(bus.any_held), 0);
    chk("reset_last_dir", 32'(bus.last_dir), DIR_NONE);
    rst = 1'b0;
    run(2);

    // clean up press, held 30 cycles
    clear_mon();
    bus.btn_raw = 5'b00001;
    run(LAT - 1);
    chk("clean_no_early_pulse", 32'(pcnt[BTN_UP]), 0);
    chk("clean_any_held_before", 32'(bus.any_held), 0);
    run(1);
    chk("clean_up_pulse", 32'(bus.up_pulse), 1);
    chk("clean_any_held", 32'(bus.any_held), 1);
    chk("clean_last_dir", 32'(bus.last_dir), DIR_UP);
    run(30 - LAT);
    chk("clean_up_count", 32'(pcnt[BTN_UP]), EXP_UP_CLEAN);
    chk("clean_first_step", 32'(first[BTN_UP]), LAT);
    chk("clean_others", 32'(pulse_sum() - pcnt[BTN_UP]), 0);
    clear_mon();
    bus.btn_raw = 5'b00000;
    run(LAT - 1);
    chk("release_held_during", 32'(bus.any_held), 1);
    run(1);
    chk("release_held_done", 32'(bus.any_held), 0);
    chk("release_no_pulse", 32'(pulse_sum()), 0);

    // left bouncing on press and release
    clear_mon();
    for (int i = 0; i < 6; i++) begin
      bus.btn_raw[BTN_LEFT] = (i % 2 == 0);
      run(1);
    end
    idx0 = idx;
    bus.btn_raw[BTN_LEFT] = 1'b1;
    run(20);
    chk("bounce_left_count", 32'(pcnt[BTN_LEFT]), 1);
    chk("bounce_left_step", 32'(first[BTN_LEFT]), 32'(idx0 + LAT));
    chk("bounce_last_dir", 32'(bus.last_dir), DIR_LEFT);
    bus.btn_raw[BTN_LEFT] = 1'b0; run(1);
    bus.btn_raw[BTN_LEFT] = 1'b1; run(1);
    bus.btn_raw[BTN_LEFT] = 1'b0; run(15);
    chk("bounce_release_count", 32'(pcnt[BTN_LEFT]), 1);
    chk("bounce_release_held", 32'(bus.any_held), 0);

    // right glitch shorter than the debounce window
    clear_mon();
    bus.btn_raw[BTN_RIGHT] = 1'b1; run(3);
    bus.btn_raw[BTN_RIGHT] = 1'b0; run(10);
    chk("glitch_pulses", 32'(pulse_sum()), 0);
    chk("glitch_held_cycles", 32'(held_cycles), 0);

    // down held, then center pressed on top of it
    clear_mon();
    bus.btn_raw = 5'b00010;
    run(10);
    chk("overlap_down_count", 32'(pcnt[BTN_DOWN]), 1);
    bus.btn_raw = 5'b10010;
    run(10);
    bus.btn_raw = 5'b00000;
    run(12);
    chk("overlap_place_locked", 32'(pcnt[BTN_CENTER]), 0);
    chk("overlap_last_dir", 32'(bus.last_dir), DIR_DOWN);
    clear_mon();
    bus.btn_raw = 5'b10000;
    run(12);
    chk("place_alone_count", 32'(pcnt[BTN_CENTER]), 1);
    chk("place_alone_step", 32'(first[BTN_CENTER]), LAT);
    chk("place_last_dir", 32'(bus.last_dir), DIR_PLACE);
    bus.btn_raw = 5'b00000;
    run(12);

    // up and right rise together
    clear_mon();
    bus.btn_raw = 5'b01001;
    run(15);
    chk("simul_up_count", 32'(pcnt[BTN_UP]), 1);
    chk("simul_up_step", 32'(first[BTN_UP]), LAT);
    chk("simul_last_dir", 32'(bus.last_dir), DIR_UP);
    bus.btn_raw = 5'b01000;
    run(12);
    chk("simul_right_never", 32'(pcnt[BTN_RIGHT]), 0);
    bus.btn_raw = 5'b00000;
    run(12);

    // reset while left is held
    clear_mon();
    bus.btn_raw = 5'b00100;
    run(12);
    chk("rst_hold_left_before", 32'(pcnt[BTN_LEFT]), 1);
    rst = 1'b1;
    run(1);
    chk("rst_hold_pulses", 32'({bus.place_pulse, bus.right_pulse, bus.left_pulse,
                                bus.down_pulse, bus.up_pulse}), 0);
    chk("rst_hold_any_held", 32'(bus.any_held), 0);
    chk("rst_hold_last_dir", 32'(bus.last_dir), DIR_NONE);
    rst = 1'b0;
    clear_mon();
    run(12);
    chk("rst_fresh_left_count", 32'(pcnt[BTN_LEFT]), 1);
    chk("rst_fresh_left_step", 32'(first[BTN_LEFT]), LAT);
    chk("rst_fresh_last_dir", 32'(bus.last_dir), DIR_LEFT);
    bus.btn_raw = 5'b00000;
    run(12);

`ifdef BTN_MOVE_AUTOREPEAT_EN
    // up held 50 cycles: original pulse then repeats at +20, +28, +36, +44
    clear_mon();
    exp_q = '{32'd8, 32'd28, 32'd36, 32'd44, 32'd52};
    bus.btn_raw = 5'b00001;
    run(50);
    bus.btn_raw = 5'b00000;
    run(15);
    chk("rpt_count", 32'(up_steps.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      chk($sformatf("rpt_step_%0d", i),
          (i < up_steps.size()) ? up_steps[i] : 32'hFFFF_FFFF, exp_q[i]);
    end
    chk("rpt_last_dir", 32'(bus.last_dir), DIR_UP);
`endif

    chk("onehot_pulses", 32'(multi), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
